program_loader: RTL and testbench

Byte-stream writer for the CPU's 256-byte program memory: it accepts a framed program image on a valid/ready byte interface, writes each payload byte into memory, and verifies the frame. The CPU is held in reset until a frame loads cleanly. It sits between the serial receive path and the CPU memory write port; the CPU fetch path is the reader of what this block writes.

---
 rtl/program_loader.sv | 172 +++++++++++++++++
 tb/tb_program_loader.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/program_loader.sv
// program_loader: framed byte-stream writer for the 256-byte program memory.
// Define LOADER_CHECKSUM_EN to add and verify the trailing CSUM byte.
module program_loader #(
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       rx_ready,
  output logic       mem_we,
  output logic [7:0] mem_addr,
  output logic [7:0] mem_wdata,
  output logic       cpu_reset,
  output logic       done,
  output logic       error
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_DATA,
    S_DONE
`ifdef LOADER_CHECKSUM_EN
    , S_CSUM
`endif
  } state_t;

  state_t        state;
  state_t        state_d;
  logic [8:0]    remaining;
  logic [7:0]    addr;
  logic [7:0]    sum;
  logic [7:0]    sum_next;
  logic [TW-1:0] idle_cnt;
  logic          accept;
  logic          in_frame;
  logic          timeout;
  logic          is_sync;
  logic          do_len;
  logic          do_wr;
  logic          do_ok;
  logic          do_fail;
  logic          do_sync;

  assign accept   = rx_valid & rx_ready;
  assign is_sync  = (rx_data == SYNC_BYTE);
  assign sum_next = sum + rx_data;

`ifdef LOADER_CHECKSUM_EN
  assign in_frame = (state == S_LEN) || (state == S_DATA)
                 || (state == S_CSUM);
`else
  assign in_frame = (state == S_LEN) || (state == S_DATA);
`endif

  // A byte arriving on the timeout cycle wins over the timeout.
  assign timeout = in_frame & ~accept & (idle_cnt == T_LAST);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_d;
    end
  end

  // Next-state decode and per-byte action strobes.
  always_comb begin
    state_d = state;
    do_len  = 1'b0;
    do_wr   = 1'b0;
    do_ok   = 1'b0;
    do_fail = 1'b0;
    do_sync = 1'b0;
    if (timeout) begin
      do_fail = 1'b1;
      state_d = S_IDLE;
    end else if (accept) begin
      unique case (state)
        S_IDLE: begin
          if (is_sync) state_d = S_LEN;
        end
        S_LEN: begin
          do_len  = 1'b1;
          state_d = S_DATA;
        end
        S_DATA: begin
          do_wr = 1'b1;
          if (remaining == 9'd1) begin
`ifdef LOADER_CHECKSUM_EN
            state_d = S_CSUM;
`else
            do_ok   = 1'b1;
            state_d = S_DONE;
`endif
          end
        end
`ifdef LOADER_CHECKSUM_EN
        S_CSUM: begin
          if (sum_next == 8'h00) begin
            do_ok   = 1'b1;
            state_d = S_DONE;
          end else begin
            do_fail = 1'b1;
            state_d = S_IDLE;
          end
        end
`endif
        S_DONE: begin
          if (is_sync) begin
            do_sync = 1'b1;
            state_d = S_LEN;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Datapath: counters, write port and status outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_ready  <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= 8'h00;
      mem_wdata <= 8'h00;
      cpu_reset <= 1'b1;
      done      <= 1'b0;
      error     <= 1'b0;
      remaining <= 9'd0;
      addr      <= 8'h00;
      sum       <= 8'h00;
      idle_cnt  <= '0;
    end else begin
      rx_ready <= 1'b1;
      mem_we   <= do_wr;
      error    <= do_fail;
      if (!in_frame || accept || timeout) begin
        idle_cnt <= '0;
      end else begin
        idle_cnt <= idle_cnt + TW'(1);
      end
      if (do_len) begin
        remaining <= (rx_data == 8'h00) ? 9'd256 : {1'b0, rx_data};
        addr      <= 8'h00;
        sum       <= 8'h00;
      end
      if (do_wr) begin
        mem_addr  <= addr;
        mem_wdata <= rx_data;
        addr      <= addr + 8'd1;
        remaining <= remaining - 9'd1;
        sum       <= sum_next;
      end
      if (do_ok) begin
        done      <= 1'b1;
        cpu_reset <= 1'b0;
      end
      if (do_sync || do_fail) begin
        done      <= 1'b0;
        cpu_reset <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader: table vectors, directed frames and random frames
// against a queue-based frame parser model.
module tb_program_loader;

  localparam int T = 16;
`ifdef LOADER_CHECKSUM_EN
  localparam bit CSUM_EN = 1'b1;
`else
  localparam bit CSUM_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       mem_we;
  logic [7:0] mem_addr;
  logic [7:0] mem_wdata;
  logic       cpu_reset;
  logic       done;
  logic       error;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  program_loader #(
    .SYNC_BYTE(8'hA5),
    .TIMEOUT_CYCLES(T)
  ) dut (
    .clk(clk),
    .reset(reset),
    .rx_data(rx_data),
    .rx_valid(rx_valid),
    .rx_ready(rx_ready),
    .mem_we(mem_we),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .cpu_reset(cpu_reset),
    .done(done),
    .error(error)
  );

  typedef struct {
    bit         v;
    logic [7:0] d;
    bit         we;
    logic [7:0] a;
    logic [7:0] wd;
    bit         dn;
    bit         er;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(bit v, logic [7:0] d, bit we,
                              logic [7:0] a, logic [7:0] wd,
                              bit dn, bit er);
    vec_t r;
    r.v = v; r.d = d; r.we = we; r.a = a; r.wd = wd;
    r.dn = dn; r.er = er;
    tbl.push_back(r);
  endfunction

  // Reference model: bytes of the frame currently being received.
  logic [7:0] fq[$];
  int         m_gap;
  bit         m_done;
  bit         e_we;
  bit         e_err;
  logic [7:0] e_addr;
  logic [7:0] e_wd;

  function automatic int plen();
    return (fq[1] == 8'h00) ? 256 : int'(fq[1]);
  endfunction

  function automatic void model_reset();
    fq.delete();
    m_gap  = 0;
    m_done = 1'b0;
    e_we   = 1'b0;
    e_err  = 1'b0;
  endfunction

  function automatic void model_cycle(bit v, logic [7:0] d);
    logic [7:0] s;
    e_we  = 1'b0;
    e_err = 1'b0;
    if (v) begin
      m_gap = 0;
      if (fq.size() == 0) begin
        if (d == 8'hA5) begin
          fq.push_back(d);
          m_done = 1'b0;
        end
      end else if (fq.size() == 1) begin
        fq.push_back(d);
      end else if (fq.size() < 2 + plen()) begin
        e_we   = 1'b1;
        e_addr = 8'(fq.size() - 2);
        e_wd   = d;
        fq.push_back(d);
        if (!CSUM_EN && fq.size() == 2 + plen()) begin
          m_done = 1'b1;
          fq.delete();
        end
      end else begin
        s = d;
        for (int i = 2; i < fq.size(); i++) s = s + fq[i];
        if (s == 8'h00) m_done = 1'b1;
        else e_err = 1'b1;
        fq.delete();
      end
    end else if (fq.size() > 0) begin
      m_gap++;
      if (m_gap == T) begin
        e_err = 1'b1;
        fq.delete();
        m_gap = 0;
      end
    end
  endfunction

  task automatic check(input string tag);
    vectors++;
    if (mem_we !== e_we
        || (e_we && (mem_addr !== e_addr || mem_wdata !== e_wd))
        || error !== e_err || done !== m_done
        || cpu_reset !== ~m_done || rx_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL %s: got we=%b a=%h d=%h err=%b done=%b crst=%b rdy=%b want we=%b a=%h d=%h err=%b done=%b",
               tag, mem_we, mem_addr, mem_wdata, error, done,
               cpu_reset, rx_ready, e_we, e_addr, e_wd, e_err,
               m_done);
    end
  endtask

  task automatic step(input bit v, input logic [7:0] d,
                      input string tag);
    @(negedge clk);
    rx_valid = v;
    rx_data  = d;
    @(posedge clk);
    #1;
    model_cycle(v, d);
    check(tag);
  endtask

  task automatic idle(input int n, input string tag);
    repeat (n) step(1'b0, 8'($urandom), tag);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    reset    = 1'b1;
    rx_valid = 1'b1;
    rx_data  = 8'($urandom);
    @(posedge clk);
    #1;
    vectors++;
    if (mem_we !== 1'b0 || mem_addr !== 8'h00 || mem_wdata !== 8'h00
        || cpu_reset !== 1'b1 || done !== 1'b0 || error !== 1'b0
        || rx_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL %s_in_reset: got we=%b a=%h d=%h crst=%b done=%b err=%b rdy=%b want 0 00 00 1 0 0 0",
               tag, mem_we, mem_addr, mem_wdata, cpu_reset, done,
               error, rx_ready);
    end
    @(negedge clk);
    reset    = 1'b0;
    rx_valid = 1'b0;
    @(posedge clk);
    #1;
    model_reset();
    model_cycle(1'b0, 8'h00);
    check({tag, "_after"});
  endtask

  logic [7:0] txq[$];

  task automatic send_txq(input int gapmax, input string tag);
    foreach (txq[i]) begin
      repeat ($urandom_range(0, gapmax)) step(1'b0, 8'($urandom), tag);
      step(1'b1, txq[i], tag);
    end
    txq.delete();
  endtask

  function automatic void build_frame(int len, bit bad, bit rnd,
                                     int first);
    logic [7:0] s;
    logic [7:0] p;
    s = 8'h00;
    txq.push_back(8'hA5);
    txq.push_back(8'(len));
    for (int i = 0; i < len; i++) begin
      p = rnd ? 8'($urandom) : 8'(first + i);
      s = s + p;
      txq.push_back(p);
    end
    if (CSUM_EN) txq.push_back(8'h00 - s + {7'd0, bad});
  endfunction

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset    = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    model_reset();

    // Directed table: garbage, frame 0A 14 20, reload, bad frame.
    add(1, 8'h00, 0, 0, 0, 0, 0);
    add(1, 8'hFF, 0, 0, 0, 0, 0);
    add(1, 8'hA5, 0, 0, 0, 0, 0);
    add(1, 8'h03, 0, 0, 0, 0, 0);
    add(1, 8'h0A, 1, 8'h00, 8'h0A, 0, 0);
    add(1, 8'h14, 1, 8'h01, 8'h14, 0, 0);
    if (CSUM_EN) begin
      add(1, 8'h20, 1, 8'h02, 8'h20, 0, 0);
      add(1, 8'hC2, 0, 0, 0, 1, 0);
    end else begin
      add(1, 8'h20, 1, 8'h02, 8'h20, 1, 0);
    end
    add(0, 8'h00, 0, 0, 0, 1, 0);
    add(1, 8'hA5, 0, 0, 0, 0, 0);
    add(1, 8'h01, 0, 0, 0, 0, 0);
    if (CSUM_EN) begin
      add(1, 8'h55, 1, 8'h00, 8'h55, 0, 0);
      add(1, 8'hAB, 0, 0, 0, 1, 0);
    end else begin
      add(1, 8'h55, 1, 8'h00, 8'h55, 1, 0);
      add(1, 8'hAB, 0, 0, 0, 1, 0);
    end
    add(1, 8'hA5, 0, 0, 0, 0, 0);
    add(1, 8'h02, 0, 0, 0, 0, 0);
    add(1, 8'h11, 1, 8'h00, 8'h11, 0, 0);
    if (CSUM_EN) begin
      add(1, 8'h22, 1, 8'h01, 8'h22, 0, 0);
      add(1, 8'h00, 0, 0, 0, 0, 1);
      add(0, 8'h00, 0, 0, 0, 0, 0);
    end else begin
      add(1, 8'h22, 1, 8'h01, 8'h22, 1, 0);
      add(1, 8'h00, 0, 0, 0, 1, 0);
      add(0, 8'h00, 0, 0, 0, 1, 0);
    end

    do_reset("reset0");
    foreach (tbl[i]) begin
      @(negedge clk);
      rx_valid = tbl[i].v;
      rx_data  = tbl[i].d;
      @(posedge clk);
      #1;
      vectors++;
      if (mem_we !== tbl[i].we
          || (tbl[i].we && (mem_addr !== tbl[i].a
                            || mem_wdata !== tbl[i].wd))
          || done !== tbl[i].dn || cpu_reset !== ~tbl[i].dn
          || error !== tbl[i].er || rx_ready !== 1'b1) begin
        miscompares++;
        $display("FAIL tbl[%0d]: got we=%b a=%h d=%h done=%b crst=%b err=%b want we=%b a=%h d=%h done=%b err=%b",
                 i, mem_we, mem_addr, mem_wdata, done, cpu_reset,
                 error, tbl[i].we, tbl[i].a, tbl[i].wd, tbl[i].dn,
                 tbl[i].er);
      end
    end

    do_reset("reset1");

    // Garbage before a one-byte frame.
    txq = '{8'h00, 8'hFF, 8'h5A};
    send_txq(0, "garbage");
    build_frame(1, 1'b0, 1'b0, 8'h7F);
    send_txq(0, "one_byte");
    idle(2, "one_byte_idle");

    // Bad checksum frame.
    txq = '{8'hA5, 8'h02, 8'h11, 8'h22, 8'h00};
    send_txq(0, "bad_csum");
    idle(3, "bad_csum_idle");

    // Full 256-byte frame, address must not wrap early.
    build_frame(256, 1'b0, 1'b0, 0);
    send_txq(0, "len256");
    idle(2, "len256_idle");

    // Timeout mid-frame, then a good frame.
    txq = '{8'hA5, 8'h04, 8'h01, 8'h02};
    send_txq(0, "to_frame");
    idle(T + 2, "timeout");
    build_frame(3, 1'b0, 1'b1, 0);
    send_txq(1, "after_to");

    // Gap of T-1 idle cycles: the byte lands on the limit and wins.
    txq = '{8'hA5, 8'h02, 8'h33};
    send_txq(0, "edge_frame");
    idle(T - 1, "edge_gap");
    step(1'b1, 8'h44, "edge_byte");
    if (CSUM_EN) step(1'b1, 8'h89, "edge_csum");
    idle(2, "edge_idle");

    // Reload from DONE.
    txq = CSUM_EN ? '{8'hA5, 8'h01, 8'h55, 8'hAB}
                  : '{8'hA5, 8'h01, 8'h55};
    send_txq(0, "reload");
    idle(2, "reload_idle");

    // Reset mid-DATA.
    txq = '{8'hA5, 8'h10, 8'h01, 8'h02, 8'h03};
    send_txq(0, "pre_reset");
    do_reset("mid_data");
    idle(3, "post_reset");

    // Random frames, garbage and truncated frames.
    for (int n = 0; n < 80; n++) begin
      int kind;
      int len;
      kind = int'($urandom_range(0, 9));
      len  = (kind == 0) ? 256 : int'($urandom_range(1, 24));
      if (kind <= 1) begin
        logic [7:0] g;
        g = 8'($urandom);
        if (g == 8'hA5) g = 8'h00;
        txq.push_back(g);
        send_txq(2, "rnd_garbage");
      end
      if (kind == 2) begin
        txq = '{8'hA5, 8'h0A};
        txq.push_back(8'($urandom));
        send_txq(2, "rnd_trunc");
        idle(T + int'($urandom_range(0, 3)), "rnd_trunc_to");
      end else begin
        build_frame(len, kind == 3, 1'b1, 0);
        send_txq((kind == 0) ? 0 : 3, "rnd_frame");
      end
      idle(int'($urandom_range(0, 2)), "rnd_idle");
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
